// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants and the IF/ID register bundle.
//   OP_*    : primary opcodes (instr[31:26]) that redirect fetch
//   NOP     : encoding loaded into the IF/ID register when a slot is squashed
//   ifid_t  : one IF/ID register entry (instruction, PC+4, valid flag)
//   branch_offset : sign-extended, word-scaled branch displacement
package mips_pkg;

  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;
  localparam logic [5:0]  OP_J   = 6'b000010;
  localparam logic [5:0]  OP_JAL = 6'b000011;
  localparam logic [31:0] NOP    = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  // imm is a word offset; scale by 4 and sign-extend to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_branch_cmp.sv
// id_branch_cmp: Decode-stage branch comparator with forwarding muxes.
//   rd1_d / rd2_d        : register-file reads for rs / rt
//   alu_out_m            : Memory-stage result available for forwarding
//   forward_a_d / _b_d   : pick alu_out_m instead of the register read
//   eq / ne              : comparison of the selected operands
// Purely combinational.
module id_branch_cmp (
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] alu_out_m,
  input  logic        forward_a_d,
  input  logic        forward_b_d,
  output logic        eq,
  output logic        ne
);

  logic [31:0] src_a;
  logic [31:0] src_b;

  always_comb begin
    src_a = forward_a_d ? alu_out_m : rd1_d;
    src_b = forward_b_d ? alu_out_m : rd2_d;
    eq    = (src_a == src_b);
    ne    = ~eq;
  end

endmodule

// File: rtl/id_fetch_redirect.sv
// id_fetch_redirect: IF/ID pipeline register plus Decode-stage control-flow
// resolution for beq/bne/j/jal.
//   CLK, reset (async, active-low)
//   InstrF, PCPlus4F          : fetched instruction and its PC+4
//   StallD                    : hold the IF/ID register (paired with StallF)
//   RD1D, RD2D, ALUOutM       : comparator operands and forwarding source
//   ForwardAD, ForwardBD      : forwarding selects
//   InstrD, PCPlus4D, ValidD  : IF/ID register contents
//   PCSrcD, Jump              : redirect requests to fetch
//   PCBranchD, PCJ            : branch target / jump target low 28 bits
//   RedirectCnt               : saturating count of taken redirects
//
// Flow control: StallD is a hold, not a handshake. While StallD=1 the slot
// is frozen and can never redirect; the redirect is re-evaluated with the
// operands present in the first unstalled cycle. A redirect squashes the
// instruction being fetched on the same edge (no delay slot).
module id_fetch_redirect
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic             StallD,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  input  logic [31:0]      ALUOutM,
  input  logic             ForwardAD,
  input  logic             ForwardBD,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             PCSrcD,
  output logic             Jump,
  output logic [31:0]      PCBranchD,
  output logic [27:0]      PCJ,
  output logic [CNT_W-1:0] RedirectCnt
);

  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       eq;
  logic       ne;
  logic [5:0] op;
  logic       take;
  logic       redirect;

  id_branch_cmp u_cmp (
    .rd1_d       (RD1D),
    .rd2_d       (RD2D),
    .alu_out_m   (ALUOutM),
    .forward_a_d (ForwardAD),
    .forward_b_d (ForwardBD),
    .eq          (eq),
    .ne          (ne)
  );

  // Redirect decode. A bubble (valid=0) never redirects, and a stalled slot
  // waits so the decision uses operands from the cycle it actually leaves.
  always_comb begin
    op       = ifid_q.instr[31:26];
    take     = ifid_q.valid & ~StallD;
    PCSrcD   = take & (((op == OP_BEQ) & eq) | ((op == OP_BNE) & ne));
    Jump     = take & ((op == OP_J) | (op == OP_JAL));
    redirect = PCSrcD | Jump;
  end

  // Targets are computed for every opcode; fetch only uses them on redirect.
  always_comb begin
    PCBranchD = ifid_q.pcplus4 + branch_offset(ifid_q.instr[15:0]);
    PCJ       = {ifid_q.instr[25:0], 2'b00};
  end

  // Stall beats flush: a stalled slot cannot redirect, so the squash branch
  // is only reachable when StallD=0.
  always_comb begin
    ifid_d = ifid_q;
    if (!StallD) begin
      if (redirect) begin
        ifid_d.instr   = NOP;
        ifid_d.pcplus4 = PCPlus4F;
        ifid_d.valid   = 1'b0;
      end else begin
        ifid_d.instr   = InstrF;
        ifid_d.pcplus4 = PCPlus4F;
        ifid_d.valid   = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redirect && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign InstrD      = ifid_q.instr;
  assign PCPlus4D    = ifid_q.pcplus4;
  assign ValidD      = ifid_q.valid;
  assign RedirectCnt = cnt_q;

endmodule

// File: tb/tb_id_fetch_redirect.sv
module tb_id_fetch_redirect;

  // ---------------- clock / reset / DUT signals ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic [31:0] InstrF, PCPlus4F, RD1D, RD2D, ALUOutM;
  logic        StallD, ForwardAD, ForwardBD;

  logic [31:0] InstrD, PCPlus4D, PCBranchD;
  logic        ValidD, PCSrcD, Jump;
  logic [27:0] PCJ;
  logic [15:0] RedirectCnt;

  // narrow-counter instance so saturation is reachable in a short run
  logic [31:0] s_InstrD, s_PCPlus4D, s_PCBranchD;
  logic        s_ValidD, s_PCSrcD, s_Jump;
  logic [27:0] s_PCJ;
  logic [3:0]  s_RedirectCnt;

  id_fetch_redirect #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .RD1D(RD1D), .RD2D(RD2D), .ALUOutM(ALUOutM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .PCSrcD(PCSrcD), .Jump(Jump), .PCBranchD(PCBranchD), .PCJ(PCJ),
    .RedirectCnt(RedirectCnt)
  );

  id_fetch_redirect #(.CNT_W(4)) dut_small (
    .CLK(CLK), .reset(reset), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .RD1D(RD1D), .RD2D(RD2D), .ALUOutM(ALUOutM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .InstrD(s_InstrD), .PCPlus4D(s_PCPlus4D), .ValidD(s_ValidD),
    .PCSrcD(s_PCSrcD), .Jump(s_Jump), .PCBranchD(s_PCBranchD), .PCJ(s_PCJ),
    .RedirectCnt(s_RedirectCnt)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // The Decode slot is modelled as plain variables; redirect rules are
  // evaluated directly from the ISA semantics with integer arithmetic.
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int unsigned m_cnt, m_cnt_s;
  logic        mp_src, mp_jmp;
  logic [31:0] mp_br;
  logic [27:0] mp_j;

  function automatic void exp_comb(output logic pcsrc, output logic jmp,
                                   output logic [31:0] pcbr, output logic [27:0] pcj);
    logic [5:0]  op;
    logic [31:0] a, b;
    int          off;
    op   = m_instr[31:26];
    a    = ForwardAD ? ALUOutM : RD1D;
    b    = ForwardBD ? ALUOutM : RD2D;
    off  = int'($signed(m_instr[15:0])) * 4;
    pcbr = m_pc4 + 32'(off);
    pcj  = 28'(m_instr[25:0] * 4);
    pcsrc = m_valid && !StallD && ((op == 6'd4 && a == b) || (op == 6'd5 && a != b));
    jmp   = m_valid && !StallD && (op == 6'd2 || op == 6'd3);
  endfunction

  always @(posedge CLK or negedge reset) begin : model
    if (!reset) begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      exp_comb(mp_src, mp_jmp, mp_br, mp_j);
      if (StallD) begin
        // slot frozen
      end else if (mp_src || mp_jmp) begin
        m_instr = '0; m_pc4 = PCPlus4F; m_valid = 1'b0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end else begin
        m_instr = InstrF; m_pc4 = PCPlus4F; m_valid = 1'b1;
      end
    end
  end

  task automatic check_model(input string tag);
    logic        e_src, e_jmp;
    logic [31:0] e_br;
    logic [27:0] e_j;
    exp_comb(e_src, e_jmp, e_br, e_j);
    check({tag, ".InstrD"},    InstrD,           m_instr);
    check({tag, ".PCPlus4D"},  PCPlus4D,         m_pc4);
    check({tag, ".ValidD"},    32'(ValidD),      32'(m_valid));
    check({tag, ".PCSrcD"},    32'(PCSrcD),      32'(e_src));
    check({tag, ".Jump"},      32'(Jump),        32'(e_jmp));
    check({tag, ".PCBranchD"}, PCBranchD,        e_br);
    check({tag, ".PCJ"},       32'(PCJ),         32'(e_j));
    check({tag, ".Cnt"},       32'(RedirectCnt), m_cnt);
    check({tag, ".CntSmall"},  32'(s_RedirectCnt), m_cnt_s);
    check({tag, ".small_rest"},
          32'({s_InstrD, s_PCPlus4D, s_ValidD, s_PCSrcD, s_Jump, s_PCBranchD, s_PCJ} ==
              {InstrD, PCPlus4D, ValidD, PCSrcD, Jump, PCBranchD, PCJ}), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr_f, pc4_f, rd1, rd2, alu;
    logic        stall, fa;
    logic [31:0] e_instr, e_pc4;
    logic        e_valid, e_pcsrc, e_jump;
    logic [31:0] e_pcbr;
    logic [27:0] e_pcj;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr_f, pc4_f, input logic stall,
                              input logic [31:0] rd1, rd2, alu, input logic fa,
                              input logic [31:0] e_instr, e_pc4,
                              input logic e_valid, e_pcsrc, e_jump,
                              input logic [31:0] e_pcbr, input logic [27:0] e_pcj,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.instr_f = instr_f; v.pc4_f = pc4_f; v.stall = stall; v.rd1 = rd1; v.rd2 = rd2;
    v.alu = alu; v.fa = fa; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_pcsrc = e_pcsrc; v.e_jump = e_jump; v.e_pcbr = e_pcbr; v.e_pcj = e_pcj;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam logic [31:0] ADDI = 32'h2008_0005;
  localparam logic [31:0] BEQM = 32'h1000_FFFE;
  localparam logic [31:0] BNE3 = 32'h1400_0003;
  localparam logic [31:0] JMP  = 32'h0800_0040;
  localparam logic [31:0] BEQ4 = 32'h1000_0004;
  localparam logic [31:0] JAL  = 32'h0C00_0010;
  localparam logic [31:0] WPTH = 32'h2009_0001;

  vec_t vecs[16];

  task automatic drive_idle();
    InstrF = 32'h0; PCPlus4F = 32'h0; StallD = 1'b0; RD1D = 32'h0; RD2D = 32'h0;
    ALUOutM = 32'h0; ForwardAD = 1'b0; ForwardBD = 1'b0;
  endtask

  initial begin : main
    logic [5:0] ops[6];
    ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd2; ops[3] = 6'd3; ops[4] = 6'h08; ops[5] = 6'h23;

    //        instr_f pc4_f  st rd1 rd2 alu fa  e_instr e_pc4 v  src jmp e_pcbr      e_pcj         cnt
    vecs[0]  = mk(ADDI, 32'h104, 0, 0, 0, 0, 0, 32'h0, 32'h0,   0, 0, 0, 32'h0,   28'h0,       16'd0);
    vecs[1]  = mk(BEQM, 32'h200, 0, 0, 0, 0, 0, ADDI,  32'h104, 1, 0, 0, 32'h118, 28'h0200014, 16'd0);
    vecs[2]  = mk(WPTH, 32'h204, 0, 7, 7, 0, 0, BEQM,  32'h200, 1, 1, 0, 32'h1F8, 28'h003FFF8, 16'd0);
    vecs[3]  = mk(BNE3, 32'h1FC, 0, 5, 9, 9, 1, 32'h0, 32'h204, 0, 0, 0, 32'h204, 28'h0,       16'd1);
    vecs[4]  = mk(BNE3, 32'h200, 0, 5, 9, 9, 1, BNE3,  32'h1FC, 1, 0, 0, 32'h208, 28'h000000C, 16'd1);
    vecs[5]  = mk(WPTH, 32'h204, 0, 5, 9, 9, 0, BNE3,  32'h200, 1, 1, 0, 32'h20C, 28'h000000C, 16'd1);
    vecs[6]  = mk(JMP,  32'h300, 0, 0, 0, 0, 0, 32'h0, 32'h204, 0, 0, 0, 32'h204, 28'h0,       16'd2);
    vecs[7]  = mk(ADDI, 32'h304, 1, 0, 0, 0, 0, JMP,   32'h300, 1, 0, 0, 32'h400, 28'h0000100, 16'd2);
    vecs[8]  = mk(ADDI, 32'h304, 1, 0, 0, 0, 0, JMP,   32'h300, 1, 0, 0, 32'h400, 28'h0000100, 16'd2);
    vecs[9]  = mk(ADDI, 32'h304, 0, 0, 0, 0, 0, JMP,   32'h300, 1, 0, 1, 32'h400, 28'h0000100, 16'd2);
    vecs[10] = mk(ADDI, 32'h104, 0, 0, 0, 0, 0, 32'h0, 32'h304, 0, 0, 0, 32'h304, 28'h0,       16'd3);
    vecs[11] = mk(BEQ4, 32'h400, 0, 0, 0, 0, 0, ADDI,  32'h104, 1, 0, 0, 32'h118, 28'h0200014, 16'd3);
    vecs[12] = mk(BEQ4, 32'h404, 0, 0, 0, 0, 0, BEQ4,  32'h400, 1, 1, 0, 32'h410, 28'h0000010, 16'd3);
    vecs[13] = mk(ADDI, 32'h414, 0, 0, 0, 0, 0, 32'h0, 32'h404, 0, 0, 0, 32'h404, 28'h0,       16'd4);
    vecs[14] = mk(JAL,  32'h500, 0, 0, 0, 0, 0, ADDI,  32'h414, 1, 0, 0, 32'h428, 28'h0200014, 16'd4);
    vecs[15] = mk(32'h0,32'h504, 0, 0, 0, 0, 0, JAL,   32'h500, 1, 0, 1, 32'h540, 28'h0000040, 16'd4);

    // ---- reset with random inputs: everything reads zero ----
    reset = 1'b0;
    InstrF = $urandom; PCPlus4F = $urandom; RD1D = $urandom; RD2D = $urandom;
    ALUOutM = $urandom; ForwardAD = 1'($urandom); ForwardBD = 1'($urandom);
    StallD = 1'b1;
    #1;
    check("rst.InstrD", InstrD, 32'h0);
    check("rst.PCPlus4D", PCPlus4D, 32'h0);
    check("rst.ValidD", 32'(ValidD), 32'h0);
    check("rst.PCSrcD", 32'(PCSrcD), 32'h0);
    check("rst.Jump", 32'(Jump), 32'h0);
    check("rst.PCBranchD", PCBranchD, 32'h0);
    check("rst.PCJ", 32'(PCJ), 32'h0);
    check("rst.Cnt", 32'(RedirectCnt), 32'h0);
    #1 reset = 1'b1;  // StallD still high: first edge must not capture

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      drive_idle();
      InstrF = vecs[i].instr_f; PCPlus4F = vecs[i].pc4_f; StallD = vecs[i].stall;
      RD1D = vecs[i].rd1; RD2D = vecs[i].rd2; ALUOutM = vecs[i].alu; ForwardAD = vecs[i].fa;
      #1;
      check($sformatf("v%0d.InstrD", i), InstrD, vecs[i].e_instr);
      check($sformatf("v%0d.PCPlus4D", i), PCPlus4D, vecs[i].e_pc4);
      check($sformatf("v%0d.ValidD", i), 32'(ValidD), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.PCSrcD", i), 32'(PCSrcD), 32'(vecs[i].e_pcsrc));
      check($sformatf("v%0d.Jump", i), 32'(Jump), 32'(vecs[i].e_jump));
      check($sformatf("v%0d.PCBranchD", i), PCBranchD, vecs[i].e_pcbr);
      check($sformatf("v%0d.PCJ", i), 32'(PCJ), 32'(vecs[i].e_pcj));
      check($sformatf("v%0d.Cnt", i), 32'(RedirectCnt), 32'(vecs[i].e_cnt));
    end

    // ---- randomized stimulus against the reference model ----
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      InstrF    = {ops[$urandom_range(0, 5)], 26'($urandom)};
      PCPlus4F  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      StallD    = ($urandom_range(0, 3) == 0);
      RD1D      = $urandom_range(0, 3);
      RD2D      = $urandom_range(0, 3);
      ALUOutM   = $urandom_range(0, 3);
      ForwardAD = 1'($urandom);
      ForwardBD = 1'($urandom);
      #1;
      check_model($sformatf("rnd%0d", i));
    end

    // ---- saturation of the narrow counter: a stream of taken jal ----
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      drive_idle();
      InstrF = JAL; PCPlus4F = 32'h800 + 32'(i * 4);
      #1;
      check_model($sformatf("sat%0d", i));
    end
    check("sat.small_is_ones", 32'(s_RedirectCnt), 32'hF);
    check("sat.wide_not_sat", 32'(RedirectCnt != 16'hFFFF), 32'd1);

    // ---- reset while a jump is pending: outputs drop immediately ----
    @(negedge CLK); drive_idle(); InstrF = JMP; PCPlus4F = 32'h900;
    #1;
    if (ValidD && InstrD == JMP) begin
      // a jal was still the current slot; keep going until JMP is in D
    end
    @(negedge CLK); drive_idle(); InstrF = JMP; PCPlus4F = 32'h900; StallD = 1'b1;
    #1 check_model("mid.stall");
    @(negedge CLK); StallD = 1'b0;
    #1 check_model("mid.release");
    #1 reset = 1'b0;
    #1;
    check("mid.Jump", 32'(Jump), 32'h0);
    check("mid.PCSrcD", 32'(PCSrcD), 32'h0);
    check("mid.PCJ", 32'(PCJ), 32'h0);
    check("mid.InstrD", InstrD, 32'h0);
    check("mid.ValidD", 32'(ValidD), 32'h0);
    check("mid.Cnt", 32'(RedirectCnt), 32'h0);
    @(negedge CLK); reset = 1'b1; StallD = 1'b1; InstrF = ADDI; PCPlus4F = 32'h104;
    @(negedge CLK); #1;
    check("post.stall_hold", InstrD, 32'h0);
    StallD = 1'b0;
    @(negedge CLK); #1;
    check("post.capture", InstrD, ADDI);
    check("post.valid", 32'(ValidD), 32'h1);
    check_model("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
